// File: rtl/synth_div_pkg.sv
// Shared types and sizing helpers for the sequential fractional divider.
package synth_div_pkg;

    typedef enum logic {IDLE, CALC} div_state_t;

    // Counter must hold Q_W+ROUND iterations with headroom.
    function automatic int cnt_w(input int q_w);
        return $clog2(q_w + 2);
    endfunction

endpackage

// File: rtl/seq_frac_divider.sv
// Saturating fraction q = min(2^Q_W-1, floor(dividend*2^Q_W/divisor)) by
// restoring division, one quotient bit per clock, optional round half-up.
module seq_frac_divider
    import synth_div_pkg::*;
#(
    parameter int NUM_W = 16,
    parameter int DEN_W = 16,
    parameter int Q_W   = 8,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             sample_now,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [Q_W-1:0]   q_out,
    output logic             busy,
    output logic             done,
    output logic             saturated,
    output logic             div_zero
);

    localparam int N     = Q_W + ROUND;
    localparam int CNT_W = cnt_w(Q_W);
    localparam int MW    = (NUM_W > DEN_W + 1) ? NUM_W : DEN_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    div_state_t       state;
    logic [DEN_W-1:0] den_r;
    logic [DEN_W:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     acc;
    logic             sat_r;
    logic             dz_r;

    // Full-width compare so any dividend >= divisor saturates regardless of widths.
    logic [MW-1:0] num_x;
    logic [MW-1:0] den_w;
    assign num_x = MW'(dividend);
    assign den_w = MW'(divisor);

    logic [DEN_W+1:0] rem_sh;
    logic [DEN_W+1:0] den_x;
    logic [DEN_W+1:0] diff;
    logic             take;
    logic [DEN_W:0]   rem_nxt;
    logic [N:0]       acc_ext;
    logic [N-1:0]     acc_nxt;
    logic [N:0]       rnd;
    logic [N:0]       q_max;
    logic [Q_W-1:0]   fin_q;
    logic             fin_sat;

    always_comb begin
        rem_sh  = {rem, 1'b0};
        den_x   = {2'b00, den_r};
        diff    = rem_sh - den_x;
        take    = (rem_sh >= den_x);
        rem_nxt = take ? diff[DEN_W:0] : rem_sh[DEN_W:0];
        acc_ext = {acc, take};
        acc_nxt = acc_ext[N-1:0];
        rnd     = ({1'b0, acc_nxt} + (N+1)'(1)) >> 1;
        q_max   = {{(N+1-Q_W){1'b0}}, {Q_W{1'b1}}};
        fin_q   = acc_nxt[Q_W-1:0];
        fin_sat = 1'b0;
        if (ROUND != 0) begin
            // Rounding up from just below 1.0 lands on 2^Q_W, which must clamp.
            if (rnd > q_max) begin
                fin_q   = '1;
                fin_sat = 1'b1;
            end else begin
                fin_q = rnd[Q_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            den_r     <= '0;
            rem       <= '0;
            cnt       <= '0;
            acc       <= '0;
            sat_r     <= 1'b0;
            dz_r      <= 1'b0;
            q_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            saturated <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_now) begin
                        den_r <= divisor;
                        rem   <= num_x[DEN_W:0];
                        cnt   <= '0;
                        acc   <= '0;
                        sat_r <= (num_x >= den_w);
                        dz_r  <= (divisor == '0);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    // Shortcut cases still run all N iterations to keep latency fixed.
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (dz_r) begin
                            q_out     <= '1;
                            saturated <= 1'b1;
                            div_zero  <= 1'b1;
                        end else if (sat_r) begin
                            q_out     <= '1;
                            saturated <= 1'b1;
                            div_zero  <= 1'b0;
                        end else begin
                            q_out     <= fin_q;
                            saturated <= fin_sat;
                            div_zero  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frac_divider.sv
// Bench: truncating and rounding divider instances fed the same stimulus.
module tb_seq_frac_divider;

    logic        tb_clk = 1'b0;
    logic        nrst = 1'b0;
    logic        sample_now = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [7:0]  q0, q1;
    logic        busy0, busy1, done0, done1, sat0, sat1, dz0, dz1;

    always #5 tb_clk = ~tb_clk;

    seq_frac_divider #(.NUM_W(16), .DEN_W(16), .Q_W(8), .ROUND(0)) dut0 (
        .clk(tb_clk), .nrst(nrst), .sample_now(sample_now), .dividend(dividend),
        .divisor(divisor), .q_out(q0), .busy(busy0), .done(done0),
        .saturated(sat0), .div_zero(dz0));

    seq_frac_divider #(.NUM_W(16), .DEN_W(16), .Q_W(8), .ROUND(1)) dut1 (
        .clk(tb_clk), .nrst(nrst), .sample_now(sample_now), .dividend(dividend),
        .divisor(divisor), .q_out(q1), .busy(busy1), .done(done1),
        .saturated(sat1), .div_zero(dz1));

    typedef struct {
        logic [15:0] num;
        logic [15:0] den;
        logic [7:0]  q0;
        logic        s0;
        logic        z0;
        logic [7:0]  q1;
        logic        s1;
        logic        z1;
    } vec_t;

    int passed = 0;
    int total = 0;
    logic [7:0] prev0 = '0;
    logic [7:0] prev1 = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: exact rational arithmetic from the result rules.
    task automatic model(input logic [15:0] n, input logic [15:0] d, input int r,
                         output logic [7:0] q, output logic s, output logic z);
        longint full;
        z = 1'b0;
        if (d == 0) begin
            q = 8'hff; s = 1'b1; z = 1'b1;
        end else if (n >= d) begin
            q = 8'hff; s = 1'b1;
        end else begin
            full = (longint'(n) << (8 + r)) / longint'(d);
            if (r == 1) full = (full + 1) >> 1;
            if (full > 255) begin
                q = 8'hff; s = 1'b1;
            end else begin
                q = 8'(full); s = 1'b0;
            end
        end
    endtask

    task automatic run_div(input string nm, input vec_t v);
        int f0, f1, c0, c1;
        f0 = 0; f1 = 0; c0 = 0; c1 = 0;
        @(negedge tb_clk);
        dividend = v.num; divisor = v.den; sample_now = 1'b1;
        @(posedge tb_clk);
        #1;
        sample_now = 1'b0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
        for (int k = 1; k <= 11; k++) begin
            @(posedge tb_clk);
            #1;
            if (k == 5) begin
                check({nm, " hold q0"}, 32'(q0), 32'(prev0));
                check({nm, " hold q1"}, 32'(q1), 32'(prev1));
                check({nm, " busy0"}, 32'(busy0), 32'd1);
                check({nm, " busy1"}, 32'(busy1), 32'd1);
            end
            if (done0) begin c0++; if (f0 == 0) f0 = k; end
            if (done1) begin c1++; if (f1 == 0) f1 = k; end
        end
        check({nm, " lat0"}, 32'(f0), 32'd8);
        check({nm, " lat1"}, 32'(f1), 32'd9);
        check({nm, " pulses0"}, 32'(c0), 32'd1);
        check({nm, " pulses1"}, 32'(c1), 32'd1);
        check({nm, " q0"}, 32'(q0), 32'(v.q0));
        check({nm, " sat0"}, 32'(sat0), 32'(v.s0));
        check({nm, " dz0"}, 32'(dz0), 32'(v.z0));
        check({nm, " q1"}, 32'(q1), 32'(v.q1));
        check({nm, " sat1"}, 32'(sat1), 32'(v.s1));
        check({nm, " dz1"}, 32'(dz1), 32'(v.z1));
        check({nm, " idle0"}, 32'(busy0), 32'd0);
        prev0 = v.q0;
        prev1 = v.q1;
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        int f0, f1, l0, l1, g;
        tbl[0] = '{16'd22000, 16'd22727, 8'd247, 1'b0, 1'b0, 8'd248, 1'b0, 1'b0};
        tbl[1] = '{16'd22256, 16'd22727, 8'd250, 1'b0, 1'b0, 8'd251, 1'b0, 1'b0};
        tbl[2] = '{16'd22726, 16'd22727, 8'd255, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0};
        tbl[3] = '{16'd22727, 16'd22727, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0};
        tbl[4] = '{16'd0,     16'd22727, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0};
        tbl[5] = '{16'd22000, 16'd0,     8'd255, 1'b1, 1'b1, 8'd255, 1'b1, 1'b1};
        tbl[6] = '{16'd1,     16'd65535, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0};

        // Reset state
        @(negedge tb_clk);
        @(negedge tb_clk);
        check("rst q0", 32'(q0), 0);      check("rst q1", 32'(q1), 0);
        check("rst busy0", 32'(busy0), 0); check("rst busy1", 32'(busy1), 0);
        check("rst done0", 32'(done0), 0); check("rst sat0", 32'(sat0), 0);
        check("rst dz0", 32'(dz0), 0);     check("rst dz1", 32'(dz1), 0);
        nrst = 1'b1;
        #1;
        check("rel q0", 32'(q0), 0);
        check("rel busy0", 32'(busy0), 0);

        for (int i = 0; i < 7; i++) run_div($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 24; i++) begin
            rv.den = 16'($urandom);
            if ($urandom_range(0, 3) != 0 && rv.den != 0)
                rv.num = 16'($urandom_range(0, int'(rv.den) - 1));
            else
                rv.num = 16'($urandom);
            model(rv.num, rv.den, 0, rv.q0, rv.s0, rv.z0);
            model(rv.num, rv.den, 1, rv.q1, rv.s1, rv.z1);
            run_div($sformatf("rnd%0d", i), rv);
        end

        // Request during CALC must be ignored
        @(negedge tb_clk);
        dividend = 16'd22000; divisor = 16'd22727; sample_now = 1'b1;
        @(posedge tb_clk);
        #1 sample_now = 1'b0;
        f0 = 0; f1 = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge tb_clk);
            if (k == 3) begin dividend = 16'd0; sample_now = 1'b1; end
            @(posedge tb_clk);
            #1 sample_now = 1'b0;
            if (done0 && f0 == 0) f0 = k;
            if (done1 && f1 == 0) f1 = k;
        end
        check("ign lat0", 32'(f0), 8);
        check("ign lat1", 32'(f1), 9);
        check("ign q0", 32'(q0), 247);
        check("ign q1", 32'(q1), 248);

        // Held request: back-to-back every N+1 cycles
        @(negedge tb_clk);
        dividend = 16'd22000; divisor = 16'd22727; sample_now = 1'b1;
        @(posedge tb_clk);
        l0 = 0; l1 = 0; f0 = 0; f1 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge tb_clk);
            #1;
            if (done0) begin
                g = (l0 == 0) ? 8 : 9;
                check("held gap0", 32'(k - l0), 32'(g));
                l0 = k; f0++;
            end
            if (done1) begin
                g = (l1 == 0) ? 9 : 10;
                check("held gap1", 32'(k - l1), 32'(g));
                l1 = k; f1++;
            end
        end
        check("held cnt0", 32'(f0), 4);
        check("held cnt1", 32'(f1), 4);
        @(negedge tb_clk);
        sample_now = 1'b0;
        repeat (12) @(negedge tb_clk);
        check("held q0", 32'(q0), 247);

        // Async reset in the middle of a division
        dividend = 16'd22256; divisor = 16'd22727; sample_now = 1'b1;
        @(posedge tb_clk);
        #1 sample_now = 1'b0;
        repeat (4) @(posedge tb_clk);
        #1 nrst = 1'b0;
        #1;
        check("abort busy0", 32'(busy0), 0);
        check("abort q0", 32'(q0), 0);
        check("abort busy1", 32'(busy1), 0);
        check("abort q1", 32'(q1), 0);
        @(negedge tb_clk);
        nrst = 1'b1;
        prev0 = '0; prev1 = '0;
        run_div("restart", tbl[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
